// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OSR       = 16;
  localparam int MID_TICK  = 7;
  localparam int LAST_TICK = 15;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs; the reset value is an input
// so idle-high and idle-low pins can share the same block.
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Metastability filter: two back-to-back flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= rst_val;
      q    <= rst_val;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 16 ticks per bit, LSB-first frames with one
// start bit, D_BITS data bits and a stop period of S_TICKS ticks.
module uart_rx
  import uart_pkg::*;
#(
  parameter int D_BITS  = 8,
  parameter int S_TICKS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              tick,
  output logic [D_BITS-1:0] rx_dout,
  output logic              rx_done_tick,
  output logic              frame_err
);

  localparam int SW = $clog2(max_int(OSR, S_TICKS));
  localparam int NW = $clog2(D_BITS);

  localparam logic [SW-1:0] S_ZERO = SW'(0);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(LAST_TICK);
  localparam logic [SW-1:0] S_STOP = SW'(S_TICKS - 1);
  localparam logic [NW-1:0] N_ZERO = NW'(0);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(D_BITS - 1);

  state_t            state, state_next;
  logic [SW-1:0]     s, s_next;
  logic [NW-1:0]     n, n_next;
  logic [D_BITS-1:0] b, b_next;
  logic [D_BITS-1:0] dout_next;
  logic              err_next;
  logic              done_next;
  logic              rx_s;
  logic              rx_prev;
  logic              fall;

  uart_sync #(.WIDTH(1)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .rst_val (1'b1),
    .d       (rx),
    .q       (rx_s)
  );

  assign fall = rx_prev & ~rx_s;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= S_ZERO;
      n            <= N_ZERO;
      b            <= {D_BITS{1'b0}};
      rx_dout      <= {D_BITS{1'b0}};
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
      rx_prev      <= 1'b1;
    end else begin
      state        <= state_next;
      s            <= s_next;
      n            <= n_next;
      b            <= b_next;
      rx_dout      <= dout_next;
      frame_err    <= err_next;
      rx_done_tick <= done_next;
      rx_prev      <= rx_s;
    end
  end

  // Next-state logic; non-tick cycles hold everything outside IDLE.
  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    dout_next  = rx_dout;
    err_next   = frame_err;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        if (fall) begin
          s_next     = S_ZERO;
          state_next = START;
        end else begin
          state_next = IDLE;
        end
      end

      START: begin
        if (tick) begin
          if (s == S_MID) begin
            s_next = S_ZERO;
            if (!rx_s) begin
              n_next     = N_ZERO;
              state_next = DATA;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s + S_ONE;
          end
        end else begin
          state_next = START;
        end
      end

      DATA: begin
        if (tick) begin
          if (s == S_LAST) begin
            s_next = S_ZERO;
            b_next = {rx_s, b[D_BITS-1:1]};
            if (n == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n + N_ONE;
            end
          end else begin
            s_next = s + S_ONE;
          end
        end else begin
          state_next = DATA;
        end
      end

      STOP: begin
        if (tick) begin
          if (s == S_STOP) begin
            // Byte is delivered even on a bad stop bit; the consumer decides.
            dout_next  = b;
            err_next   = ~rx_s;
            done_next  = 1'b1;
            s_next     = S_ZERO;
            state_next = IDLE;
          end else begin
            s_next = s + S_ONE;
          end
        end else begin
          state_next = STOP;
        end
      end

      default: begin
        s_next     = S_ZERO;
        state_next = IDLE;
      end
    endcase
  end

endmodule
